// File: rtl/simd_wb_collector_pkg.sv
// Shared definitions for the SIMD write-back collector: FSM encoding, default
// geometry and a saturating counter helper.
package simd_wb_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } wb_state_t;

    localparam int DEF_LANES    = 16;
    localparam int DEF_BEATS    = 4;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_VGPR_AW  = 10;
    localparam int DEF_SGPR_AW  = 9;
    localparam int DEF_WFID_W   = 6;
    localparam int DEF_PC_W     = 32;
    localparam int SGPR_FIELD_W = 12;
    localparam int PERF_W       = 32;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/simd_wb_beat_buffer.sv
// BEATS x LANES result storage; slot b holds lanes b*LANES .. b*LANES+LANES-1
// of the wavefront, exposed as flat vectors with slot 0 in the low bits.
module simd_wb_beat_buffer #(
    parameter int LANES  = 16,
    parameter int BEATS  = 4,
    parameter int DATA_W = 32,
    localparam int SLOT_W = $clog2(BEATS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [SLOT_W-1:0]             wr_slot,
    input  logic [LANES*DATA_W-1:0]       data,
    input  logic [LANES-1:0]              cmp,
    output logic [BEATS*LANES*DATA_W-1:0] data_flat,
    output logic [BEATS*LANES-1:0]        cmp_flat
);

    logic [BEATS-1:0][LANES*DATA_W-1:0] data_q;
    logic [BEATS-1:0][LANES-1:0]        cmp_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= '0;
            cmp_q  <= '0;
        end else if (wr_en) begin
            data_q[wr_slot] <= data;
            cmp_q[wr_slot]  <= cmp;
        end
    end

    assign data_flat = data_q;
    assign cmp_flat  = cmp_q;

endmodule

// File: rtl/simd_wb_collector.sv
// Gathers BEATS result beats into one wavefront and issues a single VGPR/VCC/SGPR
// write with grant handshake, then retires. SIMD_WB_PERF_EN adds perf counters.
module simd_wb_collector
    import simd_wb_collector_pkg::*;
#(
    parameter int LANES   = DEF_LANES,
    parameter int BEATS   = DEF_BEATS,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int VGPR_AW = DEF_VGPR_AW,
    parameter int SGPR_AW = DEF_SGPR_AW,
    parameter int WFID_W  = DEF_WFID_W,
    parameter int PC_W    = DEF_PC_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_first,
    input  logic [WFID_W-1:0]             in_wfid,
    input  logic [PC_W-1:0]               in_pc,
    input  logic [VGPR_AW-1:0]            in_vgpr_dest,
    input  logic [SGPR_FIELD_W-1:0]       in_sgpr_dest,
    input  logic                          in_vcc_wr_en,
    input  logic                          in_vgpr_wr_en,
    input  logic                          in_sgpr_wr_en,
    input  logic [LANES*BEATS-1:0]        in_exec,
    input  logic [LANES*DATA_W-1:0]       in_data,
    input  logic [LANES-1:0]              in_cmp,
    input  logic                          rf_grant,
    output logic                          vgpr_wr_en,
    output logic [VGPR_AW-1:0]            vgpr_addr,
    output logic [LANES*BEATS*DATA_W-1:0] vgpr_data,
    output logic [LANES*BEATS-1:0]        vgpr_mask,
    output logic                          vcc_wr_en,
    output logic                          sgpr_wr_en,
    output logic [SGPR_AW-1:0]            sgpr_addr,
    output logic [LANES*BEATS-1:0]        mask_value,
    output logic                          done,
    output logic [WFID_W-1:0]             done_wfid,
    output logic [PC_W-1:0]               done_pc,
    output logic                          err_proto
`ifdef SIMD_WB_PERF_EN
    ,
    output logic [PERF_W-1:0]             perf_retired,
    output logic [PERF_W-1:0]             perf_stall
`endif
);

    localparam int SLOT_W = $clog2(BEATS);
    localparam int WAVE   = LANES * BEATS;

    wb_state_t             state;
    logic [SLOT_W-1:0]     cnt;
    logic [WFID_W-1:0]     wfid_q;
    logic [PC_W-1:0]       pc_q;
    logic [VGPR_AW-1:0]    vgpr_dest_q;
    logic [SGPR_AW-1:0]    sgpr_dest_q;
    logic                  vcc_en_q;
    logic                  vgpr_en_q;
    logic                  sgpr_en_q;
    logic [WAVE-1:0]       exec_q;
    logic [WAVE-1:0]       cmp_flat;

    logic                  xfer;
    logic                  restart;
    logic                  store;
    logic                  last_beat;
    logic [SLOT_W-1:0]     slot;
    logic                  unused_sgpr_hi;

    assign in_ready  = (state == ST_IDLE) || (state == ST_COLLECT);
    assign xfer      = in_valid & in_ready;
    assign restart   = xfer & in_first;
    assign store     = restart | (xfer & (state == ST_COLLECT));
    assign slot      = in_first ? '0 : cnt;
    assign last_beat = (cnt == SLOT_W'(BEATS - 1));

    // Only the low SGPR_AW bits of the decoder field address the SGPR file.
    assign unused_sgpr_hi = ^in_sgpr_dest[SGPR_FIELD_W-1:SGPR_AW];

    simd_wb_beat_buffer #(
        .LANES  (LANES),
        .BEATS  (BEATS),
        .DATA_W (DATA_W)
    ) u_beat_buffer (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (store),
        .wr_slot   (slot),
        .data      (in_data),
        .cmp       (in_cmp),
        .data_flat (vgpr_data),
        .cmp_flat  (cmp_flat)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            wfid_q      <= '0;
            pc_q        <= '0;
            vgpr_dest_q <= '0;
            sgpr_dest_q <= '0;
            vcc_en_q    <= 1'b0;
            vgpr_en_q   <= 1'b0;
            sgpr_en_q   <= 1'b0;
            exec_q      <= '0;
            vgpr_wr_en  <= 1'b0;
            vcc_wr_en   <= 1'b0;
            sgpr_wr_en  <= 1'b0;
            done        <= 1'b0;
            err_proto   <= 1'b0;
        end else begin
            done      <= 1'b0;
            err_proto <= 1'b0;
            case (state)
                ST_IDLE, ST_COLLECT: begin
                    if (restart) begin
                        // A first beat mid-collection abandons the partial instruction.
                        err_proto   <= (state == ST_COLLECT);
                        wfid_q      <= in_wfid;
                        pc_q        <= in_pc;
                        vgpr_dest_q <= in_vgpr_dest;
                        sgpr_dest_q <= in_sgpr_dest[SGPR_AW-1:0];
                        vcc_en_q    <= in_vcc_wr_en;
                        vgpr_en_q   <= in_vgpr_wr_en;
                        sgpr_en_q   <= in_sgpr_wr_en;
                        exec_q      <= in_exec;
                        cnt         <= SLOT_W'(1);
                        state       <= ST_COLLECT;
                    end else if (xfer && (state == ST_IDLE)) begin
                        err_proto <= 1'b1;
                    end else if (xfer) begin
                        cnt <= cnt + 1'b1;
                        if (last_beat) begin
                            if (vcc_en_q || vgpr_en_q || sgpr_en_q) begin
                                vgpr_wr_en <= vgpr_en_q;
                                vcc_wr_en  <= vcc_en_q;
                                sgpr_wr_en <= sgpr_en_q;
                                state      <= ST_WRITE;
                            end else begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    if (rf_grant) begin
                        vgpr_wr_en <= 1'b0;
                        vcc_wr_en  <= 1'b0;
                        sgpr_wr_en <= 1'b0;
                        done       <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign vgpr_addr  = vgpr_dest_q;
    assign sgpr_addr  = sgpr_dest_q;
    assign vgpr_mask  = exec_q;
    assign mask_value = cmp_flat & exec_q;
    assign done_wfid  = wfid_q;
    assign done_pc    = pc_q;

`ifdef SIMD_WB_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_retired <= '0;
            perf_stall   <= '0;
        end else begin
            if (done) begin
                perf_retired <= sat_inc(perf_retired);
            end
            if ((state == ST_WRITE) && !rf_grant) begin
                perf_stall <= sat_inc(perf_stall);
            end
        end
    end
`endif

endmodule

// File: tb/tb_simd_wb_collector.sv
// Scoreboard bench for simd_wb_collector: expected writes/retires are queued as
// instructions are driven and compared when the collector writes and retires.
module tb_simd_wb_collector;

    localparam int LANES   = 16;
    localparam int BEATS   = 4;
    localparam int DATA_W  = 32;
    localparam int VGPR_AW = 10;
    localparam int SGPR_AW = 9;
    localparam int WFID_W  = 6;
    localparam int PC_W    = 32;
    localparam int WAVE    = LANES * BEATS;

    logic                          clk;
    logic                          rst;
    logic                          in_valid;
    logic                          in_ready;
    logic                          in_first;
    logic [WFID_W-1:0]             in_wfid;
    logic [PC_W-1:0]               in_pc;
    logic [VGPR_AW-1:0]            in_vgpr_dest;
    logic [11:0]                   in_sgpr_dest;
    logic                          in_vcc_wr_en;
    logic                          in_vgpr_wr_en;
    logic                          in_sgpr_wr_en;
    logic [WAVE-1:0]               in_exec;
    logic [LANES*DATA_W-1:0]       in_data;
    logic [LANES-1:0]              in_cmp;
    logic                          rf_grant;
    logic                          vgpr_wr_en;
    logic [VGPR_AW-1:0]            vgpr_addr;
    logic [WAVE*DATA_W-1:0]        vgpr_data;
    logic [WAVE-1:0]               vgpr_mask;
    logic                          vcc_wr_en;
    logic                          sgpr_wr_en;
    logic [SGPR_AW-1:0]            sgpr_addr;
    logic [WAVE-1:0]               mask_value;
    logic                          done;
    logic [WFID_W-1:0]             done_wfid;
    logic [PC_W-1:0]               done_pc;
    logic                          err_proto;
`ifdef SIMD_WB_PERF_EN
    logic [31:0]                   perf_retired;
    logic [31:0]                   perf_stall;
`endif

    simd_wb_collector dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_first      (in_first),
        .in_wfid       (in_wfid),
        .in_pc         (in_pc),
        .in_vgpr_dest  (in_vgpr_dest),
        .in_sgpr_dest  (in_sgpr_dest),
        .in_vcc_wr_en  (in_vcc_wr_en),
        .in_vgpr_wr_en (in_vgpr_wr_en),
        .in_sgpr_wr_en (in_sgpr_wr_en),
        .in_exec       (in_exec),
        .in_data       (in_data),
        .in_cmp        (in_cmp),
        .rf_grant      (rf_grant),
        .vgpr_wr_en    (vgpr_wr_en),
        .vgpr_addr     (vgpr_addr),
        .vgpr_data     (vgpr_data),
        .vgpr_mask     (vgpr_mask),
        .vcc_wr_en     (vcc_wr_en),
        .sgpr_wr_en    (sgpr_wr_en),
        .sgpr_addr     (sgpr_addr),
        .mask_value    (mask_value),
        .done          (done),
        .done_wfid     (done_wfid),
        .done_pc       (done_pc),
        .err_proto     (err_proto)
`ifdef SIMD_WB_PERF_EN
        ,
        .perf_retired  (perf_retired),
        .perf_stall    (perf_stall)
`endif
    );

    typedef struct {
        logic [WFID_W-1:0]  wfid;
        logic [PC_W-1:0]    pc;
        logic [VGPR_AW-1:0] va;
        logic [11:0]        sd;
        logic               v;
        logic               c;
        logic               s;
        logic [WAVE-1:0]    exec;
        logic [WAVE-1:0]    cmp;
        logic [31:0]        base;
    } instr_t;

    typedef struct {
        logic [WFID_W-1:0]      wfid;
        logic [PC_W-1:0]        pc;
        logic                   v;
        logic                   c;
        logic                   s;
        logic [VGPR_AW-1:0]     va;
        logic [SGPR_AW-1:0]     sa;
        logic [WAVE-1:0]        exec;
        logic [WAVE-1:0]        mask;
        logic [WAVE*DATA_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic wr_seen = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic instr_t mk(input logic [WFID_W-1:0] wfid, input logic [PC_W-1:0] pc,
                                  input logic [VGPR_AW-1:0] va, input logic [11:0] sd,
                                  input logic v, input logic c, input logic s,
                                  input logic [WAVE-1:0] exec, input logic [WAVE-1:0] cmp,
                                  input logic [31:0] base);
        instr_t t;
        t.wfid = wfid; t.pc = pc; t.va = va; t.sd = sd;
        t.v = v; t.c = c; t.s = s;
        t.exec = exec; t.cmp = cmp; t.base = base;
        return t;
    endfunction

    task automatic push_exp(input instr_t t);
        exp_t e;
        e.wfid = t.wfid; e.pc = t.pc;
        e.v = t.v; e.c = t.c; e.s = t.s;
        e.va = t.va; e.sa = t.sd[SGPR_AW-1:0];
        e.exec = t.exec;
        e.mask = t.cmp & t.exec;
        for (int i = 0; i < WAVE; i++) e.data[i*DATA_W +: DATA_W] = t.base + i;
        sb.push_back(e);
    endtask

    // Drives one beat and returns just after the edge on which it transferred.
    task automatic drive_beat(input instr_t t, input int k, input logic first);
        bit ok;
        in_valid      = 1'b1;
        in_first      = first;
        in_wfid       = t.wfid;
        in_pc         = t.pc;
        in_vgpr_dest  = t.va;
        in_sgpr_dest  = t.sd;
        in_vcc_wr_en  = t.c;
        in_vgpr_wr_en = t.v;
        in_sgpr_wr_en = t.s;
        in_exec       = t.exec;
        in_cmp        = t.cmp[k*LANES +: LANES];
        for (int j = 0; j < LANES; j++) in_data[j*DATA_W +: DATA_W] = t.base + 32'(LANES*k + j);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("ready_timeout", 0, 1);
    endtask

    task automatic send_instr(input instr_t t);
        push_exp(t);
        for (int k = 0; k < BEATS; k++) drive_beat(t, k, (k == 0));
    endtask

    // Scoreboard monitor: first strobe cycle checks write content, done pops.
    initial begin
        exp_t e;
        int bad;
        forever begin
            @(negedge clk);
            if (!rst) begin
                wr_seen = 1'b0;
            end else begin
                if ((vgpr_wr_en | vcc_wr_en | sgpr_wr_en) && !wr_seen) begin
                    wr_seen = 1'b1;
                    if (sb.size() == 0) begin
                        check("wr_unexpected", 1, 0);
                    end else begin
                        e = sb[0];
                        check("wr_vgpr_en", vgpr_wr_en, e.v);
                        check("wr_vcc_en", vcc_wr_en, e.c);
                        check("wr_sgpr_en", sgpr_wr_en, e.s);
                        check("wr_vgpr_addr", vgpr_addr, e.va);
                        check("wr_sgpr_addr", sgpr_addr, e.sa);
                        check("wr_vgpr_mask", vgpr_mask, e.exec);
                        check("wr_mask_value", mask_value, e.mask);
                        bad = 0;
                        for (int i = 0; i < WAVE; i++)
                            if (vgpr_data[i*DATA_W +: DATA_W] !== e.data[i*DATA_W +: DATA_W]) bad++;
                        check("wr_data_bad_lanes", bad, 0);
                    end
                end
                if (done) begin
                    if (sb.size() == 0) begin
                        check("done_unexpected", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("done_wfid", done_wfid, e.wfid);
                        check("done_pc", done_pc, e.pc);
                        check("done_wr_seen", wr_seen, e.v | e.c | e.s);
                    end
                    wr_seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t t, ta, tb_i;
        rst = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_wfid = '0; in_pc = '0;
        in_vgpr_dest = '0; in_sgpr_dest = '0; in_vcc_wr_en = 1'b0; in_vgpr_wr_en = 1'b0;
        in_sgpr_wr_en = 1'b0; in_exec = '0; in_data = '0; in_cmp = '0; rf_grant = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_vgpr_wr_en", vgpr_wr_en, 0);
        check("rst_vcc_wr_en", vcc_wr_en, 0);
        check("rst_sgpr_wr_en", sgpr_wr_en, 0);
        check("rst_done", done, 0);
        check("rst_err", err_proto, 0);
        check("rst_vgpr_addr", vgpr_addr, 0);
        check("rst_data_nz", |vgpr_data, 0);
        check("rst_mask_value", mask_value, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b1;

        // V_ADD-style: vgpr+vcc, full exec, lane data 16k+j.
        rf_grant = 1'b1;
        t = mk(6'd5, 32'h100, 10'h012, 12'h000, 1, 1, 0, {WAVE{1'b1}}, {WAVE{1'b1}}, 32'd0);
        send_instr(t);
        @(negedge clk);
        check("vadd_vgpr_wr_en", vgpr_wr_en, 1);
        check("vadd_vcc_wr_en", vcc_wr_en, 1);
        check("vadd_sgpr_wr_en", sgpr_wr_en, 0);
        check("vadd_in_ready", in_ready, 0);
        check("vadd_lane63", vgpr_data[63*DATA_W +: DATA_W], 63);
        check("vadd_mask_value", mask_value, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;
        @(negedge clk);
        check("vadd_done", done, 1);
        check("vadd_done_wfid", done_wfid, 5);
        check("vadd_strobe_off", vgpr_wr_en | vcc_wr_en, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("vadd_done_once", done, 0);
        check("vadd_ready_again", in_ready, 1);

        // VOP3 compare to SGPR pair.
        t = mk(6'd9, 32'h200, 10'h000, 12'h0C4, 0, 0, 1, 64'h00000000_FFFF0000, {WAVE{1'b1}}, 32'h1000);
        send_instr(t);
        @(negedge clk);
        check("vop3_sgpr_wr_en", sgpr_wr_en, 1);
        check("vop3_sgpr_addr", sgpr_addr, 9'h0C4);
        check("vop3_mask_value", mask_value, 64'h00000000_FFFF0000);
        check("vop3_vgpr_wr_en", vgpr_wr_en, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("vop3_done", done, 1);
        @(posedge clk); #1;

        // Grant withheld for five cycles.
        rf_grant = 1'b0;
        t = mk(6'd12, 32'h300, 10'h3FF, 12'hFFF, 1, 0, 1, 64'hA5A5_5A5A_F00F_0FF0,
               64'h0F0F_FFFF_3C3C_00FF, 32'h2000);
        send_instr(t);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_vgpr_wr_en", vgpr_wr_en, 1);
            check("stall_sgpr_wr_en", sgpr_wr_en, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_vgpr_addr", vgpr_addr, 10'h3FF);
            check("stall_sgpr_addr", sgpr_addr, 9'h1FF);
            check("stall_lane5", vgpr_data[5*DATA_W +: DATA_W], 32'h2005);
            check("stall_done", done, 0);
            @(posedge clk); #1;
        end
        rf_grant = 1'b1;
        @(negedge clk);
        check("stall_grant_cycle_strobe", vgpr_wr_en, 1);
        @(posedge clk); #1;
        rf_grant = 1'b0;
        @(negedge clk);
        check("stall_done_after_grant", done, 1);
        check("stall_strobe_off", vgpr_wr_en | sgpr_wr_en, 0);
        @(posedge clk); #1;

        // Non-first beat while idle is dropped.
        t = mk(6'd3, 32'h333, 10'h1, 12'h1, 1, 0, 0, {WAVE{1'b1}}, '0, 32'h0);
        drive_beat(t, 1, 1'b0);
        @(negedge clk);
        check("idle_err_proto", err_proto, 1);
        check("idle_stays_ready", in_ready, 1);
        check("idle_no_done", done, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_err_once", err_proto, 0);

        // New first beat after two beats of a partial instruction.
        rf_grant = 1'b1;
        ta   = mk(6'd1, 32'h400, 10'h055, 12'h020, 1, 0, 0, {WAVE{1'b1}}, {WAVE{1'b1}}, 32'd5000);
        tb_i = mk(6'd2, 32'h500, 10'h0AA, 12'h010, 1, 1, 1, 64'hFFFF_0000_FFFF_00FF,
                  64'h1234_5678_9ABC_DEF0, 32'h3000);
        drive_beat(ta, 0, 1'b1);
        drive_beat(ta, 1, 1'b0);
        @(negedge clk);
        check("part_no_err", err_proto, 0);
        push_exp(tb_i);
        drive_beat(tb_i, 0, 1'b1);
        @(negedge clk);
        check("restart_err_proto", err_proto, 1);
        for (int k = 1; k < BEATS; k++) drive_beat(tb_i, k, 1'b0);
        @(negedge clk);
        check("restart_strobe", vgpr_wr_en & vcc_wr_en & sgpr_wr_en, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("restart_done_wfid", done_wfid, 2);
        @(posedge clk); #1;

        // No enables: retire without any write.
        t = mk(6'd33, 32'h600, 10'h0F0, 12'h0F0, 0, 0, 0, {WAVE{1'b1}}, {WAVE{1'b1}}, 32'h4000);
        send_instr(t);
        @(negedge clk);
        check("noen_done", done, 1);
        check("noen_strobes", vgpr_wr_en | vcc_wr_en | sgpr_wr_en, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("noen_done_once", done, 0);
        check("noen_ready", in_ready, 1);

        // Reset while waiting for grant.
        rf_grant = 1'b0;
        t = mk(6'd20, 32'h700, 10'h123, 12'h045, 1, 1, 0, {WAVE{1'b1}}, {WAVE{1'b1}}, 32'h5000);
        send_instr(t);
        @(negedge clk);
        check("rstw_strobe_before", vgpr_wr_en, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rstw_vgpr_wr_en", vgpr_wr_en, 0);
        check("rstw_vcc_wr_en", vcc_wr_en, 0);
        check("rstw_vgpr_addr", vgpr_addr, 0);
        check("rstw_in_ready", in_ready, 1);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        rf_grant = 1'b1;

        // Normal instruction after the mid-write reset.
        t = mk(6'd21, 32'h800, 10'h2A2, 12'h0AB, 1, 0, 1, 64'h0F0F_0F0F_F0F0_F0F0,
               64'h00FF_00FF_FF00_FF00, 32'h6000);
        send_instr(t);
        @(negedge clk);
        check("post_rst_strobe", vgpr_wr_en & sgpr_wr_en, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rst_done", done, 1);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
